// File: rtl/llc_bufs_fill_if.sv
// Bundle between the LLC request side, the per-way SRAM banks and the set-fill engine.
// master: requester + SRAM banks; slave: the fill engine.
interface llc_bufs_fill_if #(
   parameter int LLC_WAYS    = 16,
   parameter int WAYS_PER_RD = 4,
   parameter int SET_W       = 9,
   parameter int TAG_W       = 20,
   parameter int STATE_W     = 3,
   parameter int OWNER_W     = 16,
   parameter int LINE_W      = 128
);
   localparam int WAY_W = $clog2(LLC_WAYS);

   logic                                 fetch_valid;
   logic                                 fetch_ready;
   logic [SET_W-1:0]                     fetch_set;

   logic                                 rd_en;
   logic [SET_W-1:0]                     rd_set;
   logic [WAY_W-1:0]                     rd_way_base;
   logic [WAYS_PER_RD*TAG_W-1:0]         rd_tags;
   logic [WAYS_PER_RD*STATE_W-1:0]       rd_states;
   logic [WAYS_PER_RD*OWNER_W-1:0]       rd_owners;
   logic [WAYS_PER_RD*LINE_W-1:0]        rd_lines;
   logic [WAY_W-1:0]                     rd_evict_way;

   logic [LLC_WAYS-1:0][TAG_W-1:0]       tags_buf;
   logic [LLC_WAYS-1:0][STATE_W-1:0]     states_buf;
   logic [LLC_WAYS-1:0][OWNER_W-1:0]     owners_buf;
   logic [LLC_WAYS-1:0][LINE_W-1:0]      lines_buf;
   logic [WAY_W-1:0]                     evict_way_buf;
   logic                                 fill_done;

   modport master (
      output fetch_valid, fetch_set,
      output rd_tags, rd_states, rd_owners, rd_lines, rd_evict_way,
      input  fetch_ready, rd_en, rd_set, rd_way_base,
      input  tags_buf, states_buf, owners_buf, lines_buf, evict_way_buf, fill_done
   );

   modport slave (
      input  fetch_valid, fetch_set,
      input  rd_tags, rd_states, rd_owners, rd_lines, rd_evict_way,
      output fetch_ready, rd_en, rd_set, rd_way_base,
      output tags_buf, states_buf, owners_buf, lines_buf, evict_way_buf, fill_done
   );
endinterface

// File: rtl/llc_bufs_fill.sv
// Fills the per-way LLC set buffers from the SRAM banks, WAYS_PER_RD ways per read beat.
// Latency: fill_done pulses LLC_WAYS/WAYS_PER_RD+2 cycles after accept; ready again the cycle after.
// Backpressure: fetch_ready only in IDLE; requests while busy are not queued and must be held.
module llc_bufs_fill #(
   parameter int LLC_WAYS    = 16,
   parameter int WAYS_PER_RD = 4,
   parameter int SET_W       = 9,
   parameter int TAG_W       = 20,
   parameter int STATE_W     = 3,
   parameter int OWNER_W     = 16,
   parameter int LINE_W      = 128
) (
   input logic            clk,
   input logic            rst,
   llc_bufs_fill_if.slave bus
);
   localparam int G     = LLC_WAYS / WAYS_PER_RD;
   localparam int CNT_W = $clog2(G + 1);
   localparam int WAY_W = $clog2(LLC_WAYS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(G - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] issue_cnt;
   logic             cap_vld;
   logic [CNT_W-1:0] cap_beat;
   logic             accept;

   function automatic logic [WAY_W-1:0] way_of(input logic [CNT_W-1:0] beat, input int k);
      return WAY_W'(int'(beat) * WAYS_PER_RD + k);
   endfunction

   always_comb begin
      state_d         = state_q;
      accept          = 1'b0;
      bus.fetch_ready = 1'b0;
      bus.rd_en       = 1'b0;
      bus.fill_done   = 1'b0;
      case (state_q)
         IDLE: begin
            bus.fetch_ready = 1'b1;
            if (bus.fetch_valid) begin
               accept  = 1'b1;
               state_d = READ;
            end
         end
         READ: begin
            bus.rd_en = 1'b1;
            if (issue_cnt == LAST) state_d = DRAIN;
         end
         DRAIN: state_d = DONE;
         DONE: begin
            bus.fill_done = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rd_way_base = WAY_W'(issue_cnt * WAYS_PER_RD);

   // cap_* delay rd_en and the beat index by the one-cycle SRAM read latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         issue_cnt  <= '0;
         bus.rd_set <= '0;
         cap_vld    <= 1'b0;
         cap_beat   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) bus.rd_set <= bus.fetch_set;
         if (bus.rd_en) issue_cnt <= (issue_cnt == LAST) ? '0 : issue_cnt + CNT_W'(1);
         cap_vld  <= bus.rd_en;
         cap_beat <= issue_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.tags_buf      <= '0;
         bus.states_buf    <= '0;
         bus.owners_buf    <= '0;
         bus.lines_buf     <= '0;
         bus.evict_way_buf <= '0;
      end else if (cap_vld) begin
         for (int k = 0; k < WAYS_PER_RD; k++) begin
            bus.tags_buf[way_of(cap_beat, k)]   <= bus.rd_tags[k*TAG_W +: TAG_W];
            bus.states_buf[way_of(cap_beat, k)] <= bus.rd_states[k*STATE_W +: STATE_W];
            bus.owners_buf[way_of(cap_beat, k)] <= bus.rd_owners[k*OWNER_W +: OWNER_W];
            bus.lines_buf[way_of(cap_beat, k)]  <= bus.rd_lines[k*LINE_W +: LINE_W];
         end
         if (cap_beat == '0) bus.evict_way_buf <= bus.rd_evict_way;
      end
   end
endmodule
